delay_line_arbiter: RTL and testbench
=====================================

Name: delay_line_arbiter

Overview:
- Clocked arbiter sharing one asynchronous matched-delay line (a chain of delay units, inR to outR) among N_REQ requesters.
- Each requester runs a 4-phase req/ack handshake with the arbiter.
- The arbiter grants round-robin, drives the delay line input, synchronises the delay output back into clk, and acks the granted requester.
- A timeout counter guards against a dead or unreset delay line.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SYNC_STAGES, 2, flops in the dly_return synchroniser (>=2).
- TO_W, 8, timeout counter width.
- TIMEOUT, 200, cycles allowed per delay-line edge before error (must be < 2**TO_W).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- req, in, N_REQ, per-requester 4-phase request; synchronous to clk.
- ack, out, N_REQ, per-requester 4-phase acknowledge; one-hot or zero.
- dly_launch, out, 1, drives the delay line inR.
- dly_return, in, 1, delay line outR; asynchronous, synchronised internally.
- grant_id, out, $clog2(N_REQ), index of the current or last granted requester.
- busy, out, 1, high in any state other than IDLE.
- timeout_err, out, 1, sticky; set on any edge timeout.
- err_clr, in, 1, single-cycle pulse that clears timeout_err.

Behaviour:
- Reset (rst=0, async): state=IDLE, ack=0, dly_launch=0, busy=0, grant_id=0, timeout_err=0, rr pointer=0, sync chain=0, timeout counter=0.
- Synchroniser: ret_s = dly_return after SYNC_STAGES flops. Nothing else samples dly_return directly.
- All outputs are registered.
- States: IDLE, RISE, ACKH, FALL.
- IDLE:
  - If any req bit is high, pick the first set bit starting at ptr and wrapping.
  - Next cycle: grant_id=pick, dly_launch=1, counter=0, state=RISE.
  - ptr <= pick+1 (mod N_REQ).
- RISE:
  - If ret_s==1: ack[grant_id]=1, state=ACKH.
  - Else if counter==TIMEOUT-1: timeout_err=1, ack[grant_id]=1, state=ACKH (degraded completion so the requester never hangs).
  - Otherwise counter increments.
- ACKH:
  - Hold ack and dly_launch high until req[grant_id]==0.
  - Then: dly_launch=0, counter=0, state=FALL.
  - No timeout in this state; it is requester-paced.
- FALL:
  - If ret_s==0: ack=0, state=IDLE.
  - Else if counter==TIMEOUT-1: timeout_err=1, ack=0, state=IDLE.
  - Otherwise counter increments.
- Latency, fault-free line with delay D cycles after sync:
  - req rise at cycle t gives dly_launch high at t+1.
  - ack high at t+1+D+SYNC_STAGES+1.
- Only one launch is outstanding at a time. The delay line is guaranteed quiescent (ret_s==0) before the next grant, except after a FALL timeout.
- Requests from non-granted requesters are held, not dropped. A req that falls before being granted is simply not served.
- req[grant_id] falling while in RISE: ignored until ACKH. ack still rises, and the handshake then completes immediately.
- err_clr and a timeout in the same cycle: set wins.
- Reset mid-operation: all outputs return to reset values immediately. dly_launch=0 lets the delay line drain, and the first post-reset grant waits in RISE as normal.
- N_REQ=1: arbitration degenerates and ptr stays 0.

Optional Feature:
- Macro: DELAY_LINE_ARB_LATMON_EN.
- Defined:
  - Adds output lat_cycles[15:0], which captures the RISE-state cycle count (launch to ret_s rise) when ret_s rises. It saturates at 16'hFFFF.
  - Adds output lat_valid, a 1-cycle pulse on each capture. Neither updates on timeout.
  - Reset value 0 for both.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package delay_line_arb_pkg: state enum (IDLE, RISE, ACKH, FALL), default TIMEOUT constant, latency width constant (16).
- Sub-module dla_rr_pick: combinational round-robin picker (req vector, ptr in; pick index and valid out).
- The synchroniser is an inline flop chain with async-low reset.

Test Plan:
- Single requester, delay model D=5 cycles: req[0] rise at cycle 10 gives dly_launch at 11, ack[0] at 11+5+2+1=19. Drop req at 25: dly_launch falls at 26, ack falls at 26+5+2+1=34, then busy=0.
- All four req high together, ptr=0: grant order 0,1,2,3,0. Each ack is one-hot, and no two dly_launch pulses overlap.
- Stuck-low delay line with TIMEOUT=200: timeout_err set 200 cycles after the launch cycle, ack still asserted. err_clr pulse returns it to 0, and it stays 0 on the next good transfer.
- Stuck-high dly_return during FALL: FALL times out, timeout_err=1, ack drops, state returns to IDLE.
- rst asserted during ACKH: ack, dly_launch and busy are 0 within the same cycle (async). Released with req[2] high: grant_id=2 and the handshake completes normally.
- With DELAY_LINE_ARB_LATMON_EN and D=5: lat_valid pulses with lat_cycles=7 (5+SYNC_STAGES). No pulse on a timed-out transfer.

Source files
------------

// File: rtl/delay_line_arb_pkg.sv
// Shared types and constants for the delay-line arbiter.
// Contents: FSM state enum, default per-edge timeout, latency monitor width.
package delay_line_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    ACKH = 2'd2,
    FALL = 2'd3
  } dlaState_e;

  localparam int unsigned DefaultTimeout = 200;
  localparam int unsigned LatW           = 16;

endpackage

// File: rtl/dla_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Ports:
//   reqVec  - request vector (N_REQ bits)
//   ptr     - round-robin start index
//   pick_c  - selected requester index (valid only when valid_c)
//   valid_c - at least one request is set
module dla_rr_pick
  import delay_line_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IdW   = 2
) (
  input  logic [N_REQ-1:0] reqVec,
  input  logic [IdW-1:0]   ptr,
  output logic [IdW-1:0]   pick_c,
  output logic             valid_c
);

  // Scan from the farthest offset back to ptr so the nearest set bit wins.
  always_comb begin
    int unsigned idx;
    logic [IdW-1:0] idxN;
    pick_c  = '0;
    valid_c = 1'b0;
    idx     = 0;
    idxN    = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      idx = 32'(ptr) + 32'(i);
      if (idx >= N_REQ) idx = idx - N_REQ;
      idxN = IdW'(idx);
      if (reqVec[idxN]) begin
        pick_c  = idxN;
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delay_line_arbiter.sv
// Round-robin arbiter sharing one asynchronous matched-delay line among
// N_REQ 4-phase requesters. Launches the line, synchronises its return into
// clk, acks the granted requester and guards each line edge with a timeout.
// Optional latency monitor enabled by macro DELAY_LINE_ARB_LATMON_EN.
// Ports:
//   clk, rst (async active-low)
//   req[N_REQ]      - 4-phase requests (clk-synchronous)
//   ack[N_REQ]      - 4-phase acknowledges, one-hot or zero
//   dly_launch      - delay line input
//   dly_return      - delay line output (asynchronous)
//   grant_id        - current or last granted requester
//   busy            - FSM not idle
//   timeout_err     - sticky edge-timeout flag, cleared by err_clr
//   err_clr         - clear pulse for timeout_err (a same-cycle timeout wins)
//   lat_cycles/lat_valid - launch-to-return cycle count and capture strobe
//                          (only with DELAY_LINE_ARB_LATMON_EN)
module delay_line_arbiter
  import delay_line_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned TIMEOUT     = DefaultTimeout,
  localparam int unsigned IdW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic             dly_launch,
  input  logic             dly_return,
  output logic [IdW-1:0]   grant_id,
  output logic             busy,
  output logic             timeout_err,
  input  logic             err_clr
`ifdef DELAY_LINE_ARB_LATMON_EN
  ,
  output logic [LatW-1:0]  lat_cycles,
  output logic             lat_valid
`endif
);

  localparam logic [TO_W-1:0] CntLast = TO_W'(TIMEOUT - 1);

  dlaState_e               state, stateNext;
  logic [SYNC_STAGES-1:0]  syncQ;
  logic                    retS;
  logic [TO_W-1:0]         cnt, cntNext;
  logic [IdW-1:0]          ptr, ptrNext;
  logic [IdW-1:0]          pick;
  logic                    pickValid;
  logic [N_REQ-1:0]        ackNext;
  logic                    launchNext;
  logic [IdW-1:0]          grantNext;
  logic                    busyNext;
  logic                    errNext;
`ifdef DELAY_LINE_ARB_LATMON_EN
  logic [LatW-1:0]         latCnt, latCntNext;
  logic [LatW-1:0]         latCyclesNext;
  logic                    latValidNext;
`endif

  // Return synchroniser; the only sampler of dly_return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) syncQ <= '0;
    else      syncQ <= {syncQ[SYNC_STAGES-2:0], dly_return};
  end
  assign retS = syncQ[SYNC_STAGES-1];

  dla_rr_pick #(
    .N_REQ (N_REQ),
    .IdW   (IdW)
  ) u_pick (
    .reqVec  (req),
    .ptr     (ptr),
    .pick_c  (pick),
    .valid_c (pickValid)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ack         <= '0;
      dly_launch  <= 1'b0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      ptr         <= '0;
      cnt         <= '0;
`ifdef DELAY_LINE_ARB_LATMON_EN
      latCnt      <= '0;
      lat_cycles  <= '0;
      lat_valid   <= 1'b0;
`endif
    end else begin
      state       <= stateNext;
      ack         <= ackNext;
      dly_launch  <= launchNext;
      grant_id    <= grantNext;
      busy        <= busyNext;
      timeout_err <= errNext;
      ptr         <= ptrNext;
      cnt         <= cntNext;
`ifdef DELAY_LINE_ARB_LATMON_EN
      latCnt      <= latCntNext;
      lat_cycles  <= latCyclesNext;
      lat_valid   <= latValidNext;
`endif
    end
  end

  // Next state and next output values.
  always_comb begin
    stateNext  = state;
    ackNext    = ack;
    launchNext = dly_launch;
    grantNext  = grant_id;
    cntNext    = cnt;
    ptrNext    = ptr;
    // Clear first so a timeout detected below overrides it.
    errNext    = err_clr ? 1'b0 : timeout_err;
`ifdef DELAY_LINE_ARB_LATMON_EN
    latCntNext    = latCnt;
    latCyclesNext = lat_cycles;
    latValidNext  = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (pickValid) begin
          grantNext  = pick;
          launchNext = 1'b1;
          cntNext    = '0;
          stateNext  = RISE;
          ptrNext    = (32'(pick) == N_REQ - 1) ? '0 : pick + IdW'(1);
`ifdef DELAY_LINE_ARB_LATMON_EN
          latCntNext = '0;
`endif
        end
      end
      RISE: begin
        if (retS) begin
          ackNext   = N_REQ'(1) << grant_id;
          stateNext = ACKH;
`ifdef DELAY_LINE_ARB_LATMON_EN
          latCyclesNext = latCnt;
          latValidNext  = 1'b1;
`endif
        end else if (cnt == CntLast) begin
          // Degraded completion: ack anyway so the requester cannot hang.
          errNext   = 1'b1;
          ackNext   = N_REQ'(1) << grant_id;
          stateNext = ACKH;
        end else begin
          cntNext = cnt + TO_W'(1);
`ifdef DELAY_LINE_ARB_LATMON_EN
          if (latCnt != '1) latCntNext = latCnt + LatW'(1);
`endif
        end
      end
      ACKH: begin
        if (!req[grant_id]) begin
          launchNext = 1'b0;
          cntNext    = '0;
          stateNext  = FALL;
        end
      end
      FALL: begin
        if (!retS) begin
          ackNext   = '0;
          stateNext = IDLE;
        end else if (cnt == CntLast) begin
          errNext   = 1'b1;
          ackNext   = '0;
          stateNext = IDLE;
        end else begin
          cntNext = cnt + TO_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase

    busyNext = (stateNext != IDLE);
  end

endmodule

// File: tb/tb_delay_line_arbiter.sv
// Self-checking bench for delay_line_arbiter with a D=5 cycle delay line model
// that can be forced stuck low or stuck high.
module tb_delay_line_arbiter;

  localparam int unsigned NReq = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  ack;
  logic        dly_launch;
  logic        dly_return;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;
  logic        err_clr;
`ifdef DELAY_LINE_ARB_LATMON_EN
  logic [15:0] lat_cycles;
  logic        lat_valid;
  int          latPulses = 0;
`endif

  logic [4:0]  pipe = '0;
  logic        stuckLow  = 1'b0;
  logic        stuckHigh = 1'b0;
  logic        prevLaunch = 1'b0;
  int          passCnt = 0;
  int          checkCnt = 0;
  int          sbQ[$];

  delay_line_arbiter #(
    .N_REQ       (NReq),
    .SYNC_STAGES (2),
    .TO_W        (8),
    .TIMEOUT     (200)
  ) dut (
`ifdef DELAY_LINE_ARB_LATMON_EN
    .lat_cycles  (lat_cycles),
    .lat_valid   (lat_valid),
`endif
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .ack         (ack),
    .dly_launch  (dly_launch),
    .dly_return  (dly_return),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Delay line: return follows launch by 5 clock cycles.
  always @(posedge clk) pipe <= {pipe[3:0], dly_launch};
  assign dly_return = stuckHigh ? 1'b1 : (stuckLow ? 1'b0 : pipe[4]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pop the next expected grant and compare it with the ack/grant_id now shown.
  task automatic popCheck(input string tag, output int id);
    id = 0;
    chk({tag, " sb nonempty"}, 32'(sbQ.size() != 0), 32'h1);
    if (sbQ.size() != 0) begin
      id = sbQ.pop_front();
      chk({tag, " ack"}, 32'(ack), 32'h1 << id);
      chk({tag, " grant_id"}, 32'(grant_id), 32'(id));
    end
  endtask

  task automatic waitAck(input string tag, output int id);
    int n = 0;
    while (ack === 4'b0 && n < 64) begin
      tick(1);
      n++;
    end
    chk({tag, " ack rose"}, 32'(ack !== 4'b0), 32'h1);
    popCheck(tag, id);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while ((ack !== 4'b0 || busy !== 1'b0) && n < 64) begin
      tick(1);
      n++;
    end
    chk({tag, " ack low"}, 32'(ack), 32'h0);
    chk({tag, " idle"}, 32'(busy), 32'h0);
  endtask

  // Protocol monitor: ack never multi-hot; line quiescent at every launch.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("ack onehot0", 32'($onehot0(ack)), 32'h1);
      if (dly_launch && !prevLaunch)
        chk("line quiet at launch", 32'(dly_return), 32'h0);
    end
    prevLaunch <= dly_launch;
  end

`ifdef DELAY_LINE_ARB_LATMON_EN
  always @(negedge clk) if (lat_valid === 1'b1) latPulses <= latPulses + 1;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    int latBefore;
    latBefore = 0;
    rst = 1'b0; req = 4'b0; err_clr = 1'b0;
    tick(3);
    chk("reset ack", 32'(ack), 32'h0);
    chk("reset launch", 32'(dly_launch), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset grant_id", 32'(grant_id), 32'h0);
    chk("reset timeout_err", 32'(timeout_err), 32'h0);
    rst = 1'b1;
    tick(2);

    // Single requester, exact latency (req at t, launch t+1, ack t+9).
    req = 4'b0001; sbQ.push_back(0);
    tick(1);
    chk("lat launch", 32'(dly_launch), 32'h1);
    chk("lat busy", 32'(busy), 32'h1);
    tick(7);
    chk("lat ack early", 32'(ack), 32'h0);
    tick(1);
    popCheck("lat ack t+9", id);
`ifdef DELAY_LINE_ARB_LATMON_EN
    chk("latmon valid", 32'(lat_valid), 32'h1);
    chk("latmon cycles", 32'(lat_cycles), 32'd7);
    tick(1);
    chk("latmon pulse width", 32'(lat_valid), 32'h0);
    tick(5);
`else
    tick(6);
`endif
    req = 4'b0000;
    tick(1);
    chk("fall launch low", 32'(dly_launch), 32'h0);
    chk("fall ack held", 32'(ack), 32'h1);
    tick(7);
    chk("fall ack early", 32'(ack), 32'h1);
    tick(1);
    chk("fall ack low", 32'(ack), 32'h0);
    chk("fall busy low", 32'(busy), 32'h0);

    // Round robin from ptr=0 with all four requesting; requester 0 returns.
    rst = 1'b0; tick(2); rst = 1'b1; tick(1);
    sbQ.push_back(0); sbQ.push_back(1); sbQ.push_back(2); sbQ.push_back(3); sbQ.push_back(0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      waitAck("rr", id);
      req[id] = 1'b0;
      waitIdle("rr");
      if (k == 0) req[0] = 1'b1;
    end

    // Stuck-low line: RISE timeout 200 cycles after launch; set beats clear.
`ifdef DELAY_LINE_ARB_LATMON_EN
    latBefore = latPulses;
`endif
    stuckLow = 1'b1;
    req = 4'b0010; sbQ.push_back(1);
    tick(1);
    chk("to launch", 32'(dly_launch), 32'h1);
    tick(199);
    chk("to err early", 32'(timeout_err), 32'h0);
    chk("to ack early", 32'(ack), 32'h0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("to err set wins", 32'(timeout_err), 32'h1);
    popCheck("to degraded ack", id);
    req = 4'b0000;
    waitIdle("to");
    tick(2);
    chk("to err sticky", 32'(timeout_err), 32'h1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("to err cleared", 32'(timeout_err), 32'h0);
`ifdef DELAY_LINE_ARB_LATMON_EN
    chk("latmon no pulse on timeout", 32'(latPulses), 32'(latBefore));
`endif
    stuckLow = 1'b0;
    tick(3);
    req = 4'b1000; sbQ.push_back(3);
    waitAck("good after clr", id);
    req = 4'b0000;
    waitIdle("good after clr");
    chk("err stays clear", 32'(timeout_err), 32'h0);

    // Stuck-high return during FALL: FALL timeout drops ack and idles.
    req = 4'b0001; sbQ.push_back(0);
    waitAck("fall to", id);
    stuckHigh = 1'b1;
    req = 4'b0000;
    tick(1);
    chk("fall to launch low", 32'(dly_launch), 32'h0);
    tick(199);
    chk("fall to ack held", 32'(ack), 32'h1);
    chk("fall to busy held", 32'(busy), 32'h1);
    chk("fall to err early", 32'(timeout_err), 32'h0);
    tick(1);
    chk("fall to ack low", 32'(ack), 32'h0);
    chk("fall to busy low", 32'(busy), 32'h0);
    chk("fall to err set", 32'(timeout_err), 32'h1);
    stuckHigh = 1'b0;
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(4);

    // Reset asserted in ACKH, released with only req[2] pending.
    req = 4'b0010; sbQ.push_back(1);
    waitAck("rst pre", id);
    tick(2);
    rst = 1'b0;
    #1;
    chk("rst async ack", 32'(ack), 32'h0);
    chk("rst async launch", 32'(dly_launch), 32'h0);
    chk("rst async busy", 32'(busy), 32'h0);
    chk("rst async grant_id", 32'(grant_id), 32'h0);
    req = 4'b0100;
    tick(10);
    rst = 1'b1;
    sbQ.push_back(2);
    waitAck("rst post", id);
    req = 4'b0000;
    waitIdle("rst post");

    tick(5);
    chk("sb drained", 32'(sbQ.size()), 32'h0);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
